phase_sequencer: RTL

Parametrised round-robin phase sequencer for the game top level: drives N processing phases (input sampling, game action, display refresh, …) through one-hot enable / done handshakes. Generalises the fixed three-state Input→Action→Display loop with a configurable phase count, per-phase skip mask, per-phase watchdog timeout, pause/run control and a frame counter. It sits between the top-level pin logic and the phase sub-blocks.

---
 rtl/phase_sequencer_pkg.sv | 16 +
 rtl/phase_sequencer_next_phase_sel.sv | 34 +++
 rtl/phase_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared types and helpers for the round-robin phase sequencer.
package phase_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } seq_state_t;

    localparam int MAX_PHASES = 32;

    function automatic logic [MAX_PHASES-1:0] onehot(input int unsigned idx);
        return {{(MAX_PHASES-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/phase_sequencer_next_phase_sel.sv
// Combinational round-robin finder: first unmasked index from start, with wrap.
module next_phase_sel #(
    parameter int N    = 3,
    parameter int PH_W = 2
) (
    input  logic [N-1:0]    mask,
    input  logic [PH_W-1:0] start,
    input  logic            incl,
    output logic [PH_W-1:0] idx,
    output logic            wrapped,
    output logic            none
);

    always_comb begin
        int  c;
        logic found;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        // Exclusive search reaches offset N so a lone unmasked phase selects itself.
        for (int off = 0; off <= N; off++) begin
            if (!found && (incl ? (off < N) : (off > 0))) begin
                c = (int'(start) + off) % N;
                if (!mask[c]) begin
                    found = 1'b1;
                    idx   = PH_W'(c);
                end
            end
        end
        none    = &mask;
        wrapped = found && (idx <= start);
    end

endmodule

// File: rtl/phase_sequencer.sv
// Round-robin phase sequencer with skip mask, watchdog, pause/run and frame count.
//   state  | meaning
//   IDLE   | no phase enabled; waits for run && !pause && some phase unskipped
//   ACTIVE | enable_o drives phase_o; waits for its done or the watchdog limit
//   GAP    | one dead cycle between phases; phase_o already holds the next phase
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES = 3,
    parameter int TO_W       = 16,
    parameter int FRAME_W    = 8,
    localparam int PH_W      = $clog2(NUM_PHASES)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  run_i,
    input  logic                  pause_i,
    input  logic [NUM_PHASES-1:0] skip_mask_i,
    input  logic [TO_W-1:0]       timeout_i,
    input  logic                  clr_err_i,
    input  logic [NUM_PHASES-1:0] done_i,
    output logic [NUM_PHASES-1:0] enable_o,
    output logic [PH_W-1:0]       phase_o,
    output logic [FRAME_W-1:0]    frame_o,
    output logic                  frame_tick_o,
    output logic                  timeout_o,
    output logic [PH_W-1:0]       err_phase_o
);

    seq_state_t             state_q, state_d;
    logic [NUM_PHASES-1:0]  enable_d;
    logic [PH_W-1:0]        phase_d, err_d;
    logic [FRAME_W-1:0]     frame_d;
    logic                   tick_d, to_d;
    logic [TO_W-1:0]        wd_q, wd_d;

    logic [PH_W-1:0]        idle_idx, gap_idx;
    logic                   idle_wrap, idle_none, gap_wrap, gap_none;
    logic                   done_act, wd_hit;

    next_phase_sel #(.N(NUM_PHASES), .PH_W(PH_W)) u_sel_idle (
        .mask    (skip_mask_i),
        .start   (phase_o),
        .incl    (1'b1),
        .idx     (idle_idx),
        .wrapped (idle_wrap),
        .none    (idle_none)
    );

    next_phase_sel #(.N(NUM_PHASES), .PH_W(PH_W)) u_sel_gap (
        .mask    (skip_mask_i),
        .start   (phase_o),
        .incl    (1'b0),
        .idx     (gap_idx),
        .wrapped (gap_wrap),
        .none    (gap_none)
    );

    assign done_act = done_i[phase_o];
    assign wd_hit   = (timeout_i != '0) && (wd_q == timeout_i);

    // Next phase and frame tick are resolved on the ACTIVE exit edge so that
    // the registered outputs already show them throughout the GAP cycle.
    always_comb begin
        state_d  = state_q;
        enable_d = '0;
        phase_d  = phase_o;
        frame_d  = frame_o;
        tick_d   = 1'b0;
        to_d     = timeout_o;
        err_d    = err_phase_o;
        wd_d     = '0;

        if (clr_err_i) begin
            to_d  = 1'b0;
            err_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (run_i && !pause_i && !idle_none) begin
                    phase_d  = idle_idx;
                    enable_d = NUM_PHASES'(onehot(int'(idle_idx)));
                    wd_d     = TO_W'(1);
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                enable_d = enable_o;
                wd_d     = wd_q + TO_W'(1);
                if (done_act || wd_hit) begin
                    state_d  = GAP;
                    enable_d = '0;
                    wd_d     = '0;
                    if (!done_act) begin
                        to_d  = 1'b1;
                        err_d = phase_o;
                    end
                    if (!gap_none) begin
                        phase_d = gap_idx;
                        if (gap_wrap) begin
                            frame_d = frame_o + FRAME_W'(1);
                            tick_d  = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if ((&skip_mask_i) || !run_i || pause_i) begin
                    state_d = IDLE;
                end else begin
                    state_d  = ACTIVE;
                    enable_d = NUM_PHASES'(onehot(int'(phase_o)));
                    wd_d     = TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            enable_o     <= '0;
            phase_o      <= '0;
            frame_o      <= '0;
            frame_tick_o <= 1'b0;
            timeout_o    <= 1'b0;
            err_phase_o  <= '0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            enable_o     <= enable_d;
            phase_o      <= phase_d;
            frame_o      <= frame_d;
            frame_tick_o <= tick_d;
            timeout_o    <= to_d;
            err_phase_o  <= err_d;
            wd_q         <= wd_d;
        end
    end

endmodule
